// File: rtl/biquad_cascade_scheduler.sv
// Cascade of NUM_BANDS IIR biquads sharing one 16x16 MAC; five products and one
// writeback cycle per band, with shadow/active coefficient banks swapped only in IDLE.
module biquad_cascade_scheduler #(
    parameter int NUM_BANDS = 3,
    parameter int ADDR_W    = $clog2(NUM_BANDS*5)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       out_sample,
    output logic              out_valid,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [15:0]       coef_wdata,
    input  logic              coef_commit,
    output logic              commit_pending,
    output logic              overrun
);

    localparam int NCOEF  = NUM_BANDS * 5;
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [15:0] PASS_B0 = 16'd16384;

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

    state_t state, state_nx;
    logic [BAND_W-1:0] band;
    logic [2:0]        step;

    logic signed [15:0] shadow    [NCOEF];
    logic signed [15:0] shadow_nx [NCOEF];
    logic signed [15:0] active    [NCOEF];
    logic signed [15:0] x1 [NUM_BANDS];
    logic signed [15:0] x2 [NUM_BANDS];
    logic signed [15:0] y1 [NUM_BANDS];
    logic signed [15:0] y2 [NUM_BANDS];

    logic signed [15:0] cur_x;
    logic signed [35:0] acc, acc_in, acc_nx, acc_sh;
    logic signed [15:0] coef, opnd, result;
    logic signed [31:0] prod;
    logic signed [35:0] prod_ext;
    logic [7:0]         coef_lin;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MAC;
            MAC:     if (step == 3'd4) state_nx = WB;
            WB:      state_nx = (band == LAST_BAND) ? IDLE : MAC;
            default: state_nx = IDLE;
        endcase
    end

    // Shadow write is merged first so a same-edge commit copies the updated bank.
    always_comb begin
        shadow_nx = shadow;
        if (coef_we && (32'(coef_addr) < NCOEF))
            shadow_nx[coef_addr] = coef_wdata;
    end

    always_comb begin
        coef_lin = 8'(band) * 8'd5 + 8'(step);
        coef     = active[coef_lin[ADDR_W-1:0]];
        case (step)
            3'd1:    opnd = x1[band];
            3'd2:    opnd = x2[band];
            3'd3:    opnd = y1[band];
            3'd4:    opnd = y2[band];
            default: opnd = cur_x;
        endcase
        prod     = 32'(coef) * 32'(opnd);
        prod_ext = 36'(prod);
        acc_in   = (step == 3'd0) ? '0 : acc;
        acc_nx   = (step >= 3'd3) ? acc_in - prod_ext : acc_in + prod_ext;
    end

    always_comb begin
        acc_sh = acc >>> 14;
        if (acc_sh > 36'sd32767)       result = 16'sh7FFF;
        else if (acc_sh < -36'sd32768) result = 16'sh8000;
        else                           result = acc_sh[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCOEF; i++) begin
                shadow[i] <= ((i % 5) == 0) ? PASS_B0 : '0;
                active[i] <= ((i % 5) == 0) ? PASS_B0 : '0;
            end
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                x1[b] <= '0;
                x2[b] <= '0;
                y1[b] <= '0;
                y2[b] <= '0;
            end
            cur_x          <= '0;
            acc            <= '0;
            band           <= '0;
            step           <= '0;
            out_sample     <= '0;
            out_valid      <= 1'b0;
            overrun        <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            shadow         <= shadow_nx;
            if (state == IDLE && commit_pending)
                active <= shadow_nx;
            commit_pending <= (commit_pending && state != IDLE) || coef_commit;
            if (in_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_x <= in_sample;
                        band  <= '0;
                        step  <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc_nx;
                    step <= step + 3'd1;
                end
                WB: begin
                    x2[band] <= x1[band];
                    x1[band] <= cur_x;
                    y2[band] <= y1[band];
                    y1[band] <= result;
                    cur_x    <= result;
                    step     <= '0;
                    if (band == LAST_BAND) begin
                        out_sample <= result;
                        out_valid  <= 1'b1;
                    end else begin
                        band <= band + BAND_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade_scheduler.sv
// Scoreboard bench for biquad_cascade_scheduler (NUM_BANDS=3): expected outputs are
// queued at accept time and popped when out_valid appears.
module tb_biquad_cascade_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_sample;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_commit;
    logic        commit_pending;
    logic        overrun;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    biquad_cascade_scheduler #(.NUM_BANDS(3), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready), .out_sample(out_sample), .out_valid(out_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .commit_pending(commit_pending), .overrun(overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
        in_sample = '0; coef_addr = '0; coef_wdata = '0;
        tick; tick;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        tick;
        coef_we = 1'b0;
    endtask

    task automatic commit_now;
        coef_commit = 1'b1;
        tick;
        coef_commit = 1'b0;
        n_cmp++;
        if (commit_pending !== 1'b1) begin
            n_fail++; $display("FAIL pending_set: got %b expected 1", commit_pending);
        end
        tick;
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_fail++; $display("FAIL pending_clear: got %b expected 0", commit_pending);
        end
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] e, input bit push);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL send_ready: got %b expected 1", in_ready);
        end
        in_sample = s; in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        tick;
        in_valid = 1'b0;
    endtask

    // Waits for one output; optionally pulses in_valid or a write+commit mid-sample.
    task automatic collect(input int pulse_cyc, input int commit_cyc,
                           output int lat, output logic [15:0] got);
        int          ready_bad;
        logic [15:0] e;
        lat = 0; got = '0; ready_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (c == pulse_cyc) begin
                in_valid = 1'b1; in_sample = 16'h1E61;
            end else if (c == pulse_cyc + 1) begin
                in_valid = 1'b0;
            end
            if (c == commit_cyc) begin
                coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'd8192; coef_commit = 1'b1;
            end else if (c == commit_cyc + 1) begin
                coef_we = 1'b0; coef_commit = 1'b0;
            end
            if (out_valid === 1'b1) begin
                lat = c; got = out_sample;
                if (in_ready !== 1'b1) ready_bad++;
                break;
            end
            if (in_ready !== 1'b0) ready_bad++;
        end
        n_cmp++;
        if (ready_bad != 0) begin
            n_fail++; $display("FAIL in_ready_busy: got %0d bad cycles expected 0", ready_bad);
        end
        n_cmp++;
        if (lat == 0) begin
            n_fail++; $display("FAIL out_timeout: got no out_valid expected one within 40 cycles");
        end else if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL out_unexpected: got %0d expected no output", $signed(got));
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++; $display("FAIL out_sample: got %0d expected %0d", $signed(got), $signed(e));
            end
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp += 5;
        if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (out_sample !== 16'd0)   begin n_fail++; $display("FAIL rst_out_sample: got %0d expected 0", out_sample); end
        if (overrun !== 1'b0)       begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b expected 0", commit_pending); end
    endtask

    task automatic test_latency;
        int lat; logic [15:0] got;
        send(16'd1000, 16'd1000, 1'b1);
        collect(0, 0, lat, got);
        n_cmp++;
        if (lat != 18) begin n_fail++; $display("FAIL latency: got %0d expected 18", lat); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_idle: got %b expected 0", overrun); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [15:0] got;
        do_reset;
        wr_coef(4'd0, 16'd8192);
        wr_coef(4'd1, 16'd8192);
        wr_coef(4'd15, 16'h7FFF);
        commit_now;
        send(16'd1000, 16'd500, 1'b1);  collect(0, 0, lat, got);
        send(16'd1000, 16'd1000, 1'b1); collect(0, 0, lat, got);
        send(16'd2000, 16'd1500, 1'b1); collect(0, 0, lat, got);
        n_cmp++;
        if (lat != 18) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 18", lat); end
    endtask

    task automatic test_lowpass;
        int lat; logic [15:0] got, prev; longint y, t;
        do_reset;
        wr_coef(4'd0, 16'd1638);
        wr_coef(4'd3, 16'(-14746));
        commit_now;
        y = 0; prev = '0;
        for (int k = 0; k < 6; k++) begin
            t = 64'(1638 * 10000) + 64'(14746) * y;
            y = t >>> 14;
            send(16'd10000, 16'(y), 1'b1);
            collect(0, 0, lat, got);
            if (k > 0) begin
                n_cmp++;
                if (!($signed(got) > $signed(prev))) begin
                    n_fail++; $display("FAIL lp_monotonic: got %0d expected above %0d", $signed(got), $signed(prev));
                end
            end
            prev = got;
        end
    endtask

    task automatic test_saturation;
        int lat; logic [15:0] got;
        do_reset;
        wr_coef(4'd0, 16'd32766);
        wr_coef(4'd5, 16'd32766);
        wr_coef(4'd10, 16'd32766);
        commit_now;
        send(16'd20000, 16'h7FFF, 1'b1);    collect(0, 0, lat, got);
        send(16'(-20000), 16'h8000, 1'b1);  collect(0, 0, lat, got);
    endtask

    task automatic test_overrun_commit;
        int lat; logic [15:0] got;
        do_reset;
        send(16'd1000, 16'd1000, 1'b1);
        collect(5, 8, lat, got);
        n_cmp += 2;
        if (overrun !== 1'b1)        begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL pending_busy: got %b expected 1", commit_pending); end
        send(16'd1000, 16'd500, 1'b1);
        n_cmp++;
        if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL pending_idle_edge: got %b expected 0", commit_pending); end
        collect(0, 0, lat, got);
        n_cmp++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [15:0] got; bit seen;
        send(16'd1000, 16'd0, 1'b0);
        for (int c = 1; c <= 7; c++) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        n_cmp += 4;
        if (in_ready !== 1'b1)       begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        if (overrun !== 1'b0)        begin n_fail++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL mid_pending: got %b expected 0", commit_pending); end
        if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL mid_aborted: got out_valid expected none"); end
        send(16'd1000, 16'd1000, 1'b1);
        collect(0, 0, lat, got);
    endtask

    initial begin
        test_reset;
        test_latency;
        test_back_to_back;
        test_lowpass;
        test_saturation;
        test_overrun_commit;
        test_reset_mid;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL leftover_expected: got %0d queued expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/biquad_cascade_scheduler.md
Name: biquad_cascade_scheduler

Overview:
Time-multiplexes one shared 16x16 multiplier/accumulator across NUM_BANDS cascaded IIR biquad sections for the audio EQ path. Each accepted input sample runs in order through band 0, band 1, and so on up to band NUM_BANDS-1. The block owns the per-band coefficient banks (shadow and active) and the per-band history, and swaps coefficients only at sample boundaries.

Parameters:
NUM_BANDS, 3, number of cascaded biquad sections; legal range 1..8.
ADDR_W, $clog2(NUM_BANDS*5), width of the coefficient address.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low; clears all state on a clk edge while 0
in_sample  in  16  signed input sample
in_valid  in  1  input sample strobe
in_ready  out  1  high while IDLE; a sample is accepted on a clk edge with in_valid && in_ready
out_sample  out  16  signed cascade output
out_valid  out  1  one-cycle strobe marking out_sample as new
coef_we  in  1  write strobe for the shadow coefficient bank
coef_addr  in  ADDR_W  address = band*5 + idx, where idx 0..4 = b0,b1,b2,a1,a2
coef_wdata  in  16  signed coefficient, Q2.14
coef_commit  in  1  request to copy the shadow bank into the active bank
commit_pending  out  1  commit requested but not yet applied
overrun  out  1  sticky flag: in_valid arrived while busy

Behaviour:
- Reset (reset==0 at an edge) sets:
  - both coefficient banks, every band, to passthrough: b0=16384, b1=b2=a1=a2=0
  - all history (x1, x2, y1, y2 per band) to 0
  - out_sample=0, out_valid=0, overrun=0, commit_pending=0
  - state IDLE, so in_ready=1
- Reset mid-computation aborts the sample; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1.
  - MAC(band, step 0..4): one product per cycle, in the order b0*x, b1*x1, b2*x2, -(a1*y1), -(a2*y2).
  - WB(band): writeback.
- Transitions:
  - IDLE goes to MAC(0,0) on accept; the sample is latched as the band-0 input.
  - MAC step 4 goes to WB.
  - WB(b) goes to MAC(b+1,0), or to IDLE if b==NUM_BANDS-1.
- Arithmetic:
  - Products are 32-bit signed.
  - The 36-bit signed accumulator clears at step 0.
  - Result = acc >>> 14 (arithmetic shift, floor), then saturated to [-32768, 32767].
- Writeback:
  - History updates: x2<=x1, x1<=band input, y2<=y1, y1<=saturated result.
  - The saturated result becomes the next band's input.
- Output:
  - On the last WB edge: out_sample <= result, out_valid=1 for exactly one cycle.
  - The block is back in IDLE on that same cycle.
  - Latency: out_valid rises 6*NUM_BANDS edges after the accept edge (18 for the default).
- Throughput: one sample per 6*NUM_BANDS cycles. A new sample may be accepted in the cycle where out_valid=1.
- Overrun: in_valid while not IDLE is ignored and sets overrun=1. overrun stays set until reset. The in-flight computation is unaffected.
- Coefficient writes:
  - coef_we writes the shadow bank at any time, including while busy.
  - coef_addr >= NUM_BANDS*5 is ignored.
  - The active bank is never written directly.
- Commit:
  - coef_commit sets commit_pending.
  - On the first edge in IDLE with commit_pending=1, active <= shadow and commit_pending clears.
  - A sample accepted on that same edge uses the new coefficients.
  - A commit arriving while busy does not affect the sample in flight.
  - coef_commit and coef_we on the same edge: the write lands in shadow first, and the commit copies the updated shadow.
  - History is preserved across commits.

Test Plan:
- Default coefficients, NUM_BANDS=3, in_sample=1000 accepted -> out_valid exactly 18 cycles later, out_sample=1000; in_ready=0 for those 18 cycles.
- Program band0 b0=8192, b1=8192, then commit; feed 1000, 1000, 2000 -> outputs 500, 1000, 1500.
- Band0 b0=1638, a1=-14746, commit; step input 10000 -> first output 999, second output 1898 (floor arithmetic, history fed back correctly), monotonic rise toward ~10000.
- All three bands b0=32766; in_sample=20000 -> out_sample=32767; in_sample=-20000 -> -32768 (saturation applied per band).
- in_valid pulsed 5 cycles after an accept -> ignored, overrun=1 and stays 1, output of the first sample is correct; a coef_commit issued mid-sample -> the current sample uses old coefficients, the next sample uses new ones, commit_pending drops on the IDLE edge.
- reset=0 asserted 7 cycles into a sample -> no out_valid; next cycle in_ready=1, coefficients back to passthrough, overrun=0, and the next 1000 input yields 1000.
